pe_array_sequencer: RTL and testbench
=====================================

Name: pe_array_sequencer

Overview:
- Sequences an N x N weight-stationary array of PE tiles through one job: weight load, skewed activation stream, pipeline drain.
- Drives per-row weight load strobes, per-row skewed input_valid, and a latched float mode.
- Collects PE overflow into a sticky flag and reports busy/done to the host-side controller.
- Sits between the activation/weight buffers and the PE grid.

Parameters:
N, 4, array dimension (rows = columns); legal 2..16
CNT_W, 8, width of the vector-count input and internal vector counter
DRAIN_LEN, 9, cycles spent in DRAIN after the last activation (N-1 skew + N column hops + 2 register stages)

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
start  input  1  job request; sampled only in IDLE
num_vectors  input  CNT_W  activation vectors in the job; latched on accepted start
float_mode  input  1  numeric mode for the job; latched on accepted start
weight_valid  input  1  weight row available from the buffer
weight_ready  output  1  sequencer accepts a weight row
act_valid  input  1  activation vector available
act_ready  output  1  sequencer accepts an activation vector
ovf_in  input  1  OR of all PE overflow outputs
load_row  output  N  one-hot weight load strobe; bit i drives load of every PE in row i
row_valid  output  N  skewed input_valid; bit i feeds row i, column 0
float  output  1  latched float_mode to all PEs
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at job end
ovf_flag  output  1  sticky overflow for the current/last job

Behaviour:
- Reset values: state IDLE, all counters 0, skew pipeline 0. Outputs: weight_ready=0, act_ready=0, load_row=0, row_valid=0, float=0, busy=0, done=0, ovf_flag=0.
- Reset mid-job returns to IDLE immediately and discards the job. Skew pipeline clears.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 with num_vectors!=0: latch num_vectors and float_mode, clear ovf_flag, set row_cnt=0, go to LOAD_W.
  - start=1 with num_vectors==0: latch float_mode, clear ovf_flag, go to DONE (no load, no stream).
- LOAD_W:
  - weight_ready=1.
  - load_row[row_cnt] = weight_valid; this output is combinational. All other bits are 0.
  - On each handshake (weight_valid & weight_ready), row_cnt increments.
  - On the handshake with row_cnt==N-1, go to STREAM with vec_cnt=0.
  - Stalls (weight_valid=0) hold state with load_row=0.
- STREAM:
  - act_ready=1.
  - A handshake at cycle t asserts row_valid[i] at cycle t+1+i. Implement as a registered shift chain, bit 0 registered from the handshake and bit i from bit i-1.
  - Bubbles (act_valid=0) propagate through the chain as gaps.
  - vec_cnt increments per handshake. On the handshake with vec_cnt==latched count-1, go to DRAIN with drain_cnt=0.
- DRAIN:
  - act_ready=0, weight_ready=0.
  - The skew chain keeps shifting.
  - Stay exactly DRAIN_LEN cycles, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- The skew chain shifts in every state; in non-STREAM states its input is 0.
- float: registered, updated only on accepted start, held through the job and afterwards.
- start in any state other than IDLE is ignored.
- A start in the same cycle as DONE is ignored; the earliest new start is accepted in the following IDLE cycle.
- ovf_flag:
  - Set when ovf_in=1 in any busy state, including DONE.
  - Holds until the next accepted start.
  - ovf_in in IDLE is ignored.
- busy=1 in LOAD_W, STREAM, DRAIN and DONE.
- Counters never wrap: num_vectors = 2^CNT_W-1 (255) streams exactly 255 vectors.

Test Plan:
- Reset/idle: n_rst low → all outputs 0. Release, hold start=0 for 10 cycles → remain IDLE, busy=0.
- Basic job, N=4:
  - Stimulus: start with num_vectors=3, float_mode=1; weight_valid and act_valid held high.
  - load_row: 0001, 0010, 0100, 1000 on 4 consecutive cycles.
  - act_ready high 3 cycles. row_valid[0] high 3 cycles starting 1 cycle after the first handshake; row_valid[3] delayed 3 more cycles.
  - DRAIN 9 cycles, then done pulses once. float=1 throughout.
- Stalls: weight_valid toggled 1,0,1,0 pattern and act_valid with a 1-cycle gap → load_row only on handshake cycles; the row_valid gap appears in each row, shifted by its index.
- Zero-length job: start with num_vectors=0 → no load_row/row_valid activity; busy high for 1 cycle (DONE), done pulses 1 cycle after start.
- Overflow: pulse ovf_in for 1 cycle during STREAM → ovf_flag=1 through done and IDLE. Next start clears it. ovf_in pulse in IDLE leaves ovf_flag=0.
- Abort and ignored start: start with num_vectors=5, then assert n_rst mid-STREAM → immediate IDLE, all outputs 0. Separately, start pulse during STREAM has no effect on vec_cnt or state.

Source files
------------

// File: rtl/pe_array_sequencer_if.sv
// Handshake and control bundle between the host/buffer side and the PE array
// sequencer. The master side is the host plus the weight/activation buffers;
// the slave side is the sequencer itself.
interface pe_array_sequencer_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic             float_mode;
  logic             weight_valid;
  logic             weight_ready;
  logic             act_valid;
  logic             act_ready;
  logic             ovf_in;
  logic [N-1:0]     load_row;
  logic [N-1:0]     row_valid;
  logic             float;
  logic             busy;
  logic             done;
  logic             ovf_flag;

  modport master (
    output start, num_vectors, float_mode, weight_valid, act_valid, ovf_in,
    input  weight_ready, act_ready, load_row, row_valid, float, busy, done, ovf_flag
  );

  modport slave (
    input  start, num_vectors, float_mode, weight_valid, act_valid, ovf_in,
    output weight_ready, act_ready, load_row, row_valid, float, busy, done, ovf_flag
  );
endinterface

// File: rtl/pe_array_sequencer.sv
// Job sequencer for an N x N weight-stationary PE array: loads one weight row
// per handshake, streams activations through a per-row skew chain, waits for
// the array pipeline to drain, then pulses done. Collects PE overflow into a
// sticky flag that lives until the next accepted job.
module pe_array_sequencer #(
  parameter int N         = 4,
  parameter int CNT_W     = 8,
  parameter int DRAIN_LEN = 9
) (
  input  logic                 clk,
  input  logic                 n_rst,
  pe_array_sequencer_if.slave  bus
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_r;
  logic [RW-1:0]    row_cnt_r;
  logic [CNT_W-1:0] vec_cnt_r;
  logic [CNT_W-1:0] num_r;
  logic [DW-1:0]    drain_cnt_r;
  logic [N-1:0]     skew_r;
  logic [N-1:0]     load_row_s;
  logic             weight_ready_r;
  logic             act_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             float_r;
  logic             ovf_flag_r;
  logic             w_hs_s;
  logic             a_hs_s;

  // Ready flags are only ever high in their own phase, so they qualify the handshakes.
  assign w_hs_s = bus.weight_valid & weight_ready_r;
  assign a_hs_s = bus.act_valid & act_ready_r;

  // Weight load strobe follows weight_valid in the same cycle, steered to the current row.
  always_comb begin
    load_row_s = '0;
    if ((state_r == LOAD_W) && bus.weight_valid) begin
      load_row_s = {{(N-1){1'b0}}, 1'b1} << row_cnt_r;
    end else begin
      load_row_s = '0;
    end
  end

  // Skew chain: row i sees an activation handshake i+1 cycles after it happened.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      skew_r <= '0;
    end else begin
      skew_r <= {skew_r[N-2:0], a_hs_s};
    end
  end

  // Job FSM with registered status outputs, latched mode and sticky overflow.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r        <= IDLE;
      row_cnt_r      <= '0;
      vec_cnt_r      <= '0;
      num_r          <= '0;
      drain_cnt_r    <= '0;
      weight_ready_r <= 1'b0;
      act_ready_r    <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      float_r        <= 1'b0;
      ovf_flag_r     <= 1'b0;
    end else begin
      // Overflow is only meaningful while a job owns the array.
      if ((state_r != IDLE) && bus.ovf_in) begin
        ovf_flag_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            float_r    <= bus.float_mode;
            ovf_flag_r <= 1'b0;
            busy_r     <= 1'b1;
            if (bus.num_vectors != {CNT_W{1'b0}}) begin
              num_r          <= bus.num_vectors;
              row_cnt_r      <= '0;
              weight_ready_r <= 1'b1;
              state_r        <= LOAD_W;
            end else begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        LOAD_W: begin
          if (w_hs_s) begin
            if (row_cnt_r == RW'(N - 1)) begin
              vec_cnt_r      <= '0;
              weight_ready_r <= 1'b0;
              act_ready_r    <= 1'b1;
              state_r        <= STREAM;
            end else begin
              row_cnt_r <= row_cnt_r + RW'(1);
            end
          end
        end
        STREAM: begin
          if (a_hs_s) begin
            if (vec_cnt_r == (num_r - CNT_W'(1))) begin
              drain_cnt_r <= '0;
              act_ready_r <= 1'b0;
              state_r     <= DRAIN;
            end else begin
              vec_cnt_r <= vec_cnt_r + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_r == DW'(DRAIN_LEN - 1)) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          weight_ready_r <= 1'b0;
          act_ready_r    <= 1'b0;
          busy_r         <= 1'b0;
          done_r         <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

  assign bus.weight_ready = weight_ready_r;
  assign bus.act_ready    = act_ready_r;
  assign bus.load_row     = load_row_s;
  assign bus.row_valid    = skew_r;
  assign bus.float        = float_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.ovf_flag     = ovf_flag_r;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Bench for pe_array_sequencer: each directed window is turned into an
// expected per-cycle timeline (job phases walked from the handshake rules),
// and a negedge process compares every DUT output against that timeline.
module tb_pe_array_sequencer;
  localparam int N         = 4;
  localparam int CNT_W     = 8;
  localparam int DRAIN_LEN = 9;
  localparam int L         = 320;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  pe_array_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

  pe_array_sequencer #(.N(N), .CNT_W(CNT_W), .DRAIN_LEN(DRAIN_LEN)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // stimulus per window cycle
  bit s_start [L+1];
  bit s_wv    [L+1];
  bit s_av    [L+1];
  bit s_ovf   [L+1];
  int nv;
  bit fm;

  // expected timeline
  logic [N-1:0] e_load [L+1];
  logic [N-1:0] e_rv   [L+1];
  bit e_wr [L+1], e_ar [L+1], e_busy [L+1], e_done [L+1], e_acc [L+1];
  bit e_float [L+1], e_ovf [L+1];
  bit m_float, m_ovf;

  int cyc;
  bit chk_en;
  int n_chk;
  int n_fail;

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c <= L; c++) begin
      s_start[c] = 1'b0; s_wv[c] = 1'b0; s_av[c] = 1'b0; s_ovf[c] = 1'b0;
    end
    nv = 0;
    fm = 1'b0;
  endtask

  // Walk the job phases across the window to build expected outputs.
  task automatic build(input int len);
    int t;
    int rows;
    int k;
    for (int c = 0; c <= L; c++) begin
      e_load[c] = '0; e_rv[c] = '0; e_wr[c] = 0; e_ar[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_acc[c] = 0; e_float[c] = 0; e_ovf[c] = 0;
    end
    t = 0;
    while (t < len) begin
      if (!s_start[t]) begin
        t++;
        continue;
      end
      e_acc[t] = 1;
      t++;
      if (nv == 0) begin
        if (t <= L) begin e_busy[t] = 1; e_done[t] = 1; end
        t++;
      end else begin
        rows = 0;
        while (rows < N && t <= L) begin
          e_busy[t] = 1; e_wr[t] = 1;
          if (s_wv[t]) begin
            e_load[t] = {{(N-1){1'b0}}, 1'b1} << rows;
            rows++;
          end
          t++;
        end
        k = 0;
        while (k < nv && t <= L) begin
          e_busy[t] = 1; e_ar[t] = 1;
          if (s_av[t]) begin
            for (int i = 0; i < N; i++)
              if (t + 1 + i <= L) e_rv[t+1+i][i] = 1'b1;
            k++;
          end
          t++;
        end
        for (int d = 0; d < DRAIN_LEN; d++) begin
          if (t <= L) e_busy[t] = 1;
          t++;
        end
        if (t <= L) begin e_busy[t] = 1; e_done[t] = 1; end
        t++;
      end
    end
    e_float[0] = m_float;
    e_ovf[0]   = m_ovf;
    for (int c = 0; c < len; c++) begin
      e_float[c+1] = e_acc[c] ? fm : e_float[c];
      e_ovf[c+1]   = e_acc[c] ? 1'b0 : (e_ovf[c] | (e_busy[c] & s_ovf[c]));
    end
  endtask

  task automatic run_window(input int len);
    build(len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      cyc              = c;
      chk_en           = 1'b1;
      bus.start        = s_start[c];
      bus.num_vectors  = CNT_W'(nv);
      bus.float_mode   = fm;
      bus.weight_valid = s_wv[c];
      bus.act_valid    = s_av[c];
      bus.ovf_in       = s_ovf[c];
    end
    @(negedge clk);
    #1;
    chk_en  = 1'b0;
    m_float = e_float[len];
    m_ovf   = e_ovf[len];
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_weight_ready"}, -1, 32'(bus.weight_ready), 32'd0);
    chk({tag, "_act_ready"},    -1, 32'(bus.act_ready),    32'd0);
    chk({tag, "_load_row"},     -1, 32'(bus.load_row),     32'd0);
    chk({tag, "_row_valid"},    -1, 32'(bus.row_valid),    32'd0);
    chk({tag, "_float"},        -1, 32'(bus.float),        32'd0);
    chk({tag, "_busy"},         -1, 32'(bus.busy),         32'd0);
    chk({tag, "_done"},         -1, 32'(bus.done),         32'd0);
    chk({tag, "_ovf_flag"},     -1, 32'(bus.ovf_flag),     32'd0);
  endtask

  // Per-cycle comparison of every output against the expected timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("load_row",     cyc, 32'(bus.load_row),     32'(e_load[cyc]));
      chk("row_valid",    cyc, 32'(bus.row_valid),    32'(e_rv[cyc]));
      chk("weight_ready", cyc, 32'(bus.weight_ready), 32'(e_wr[cyc]));
      chk("act_ready",    cyc, 32'(bus.act_ready),    32'(e_ar[cyc]));
      chk("busy",         cyc, 32'(bus.busy),         32'(e_busy[cyc]));
      chk("done",         cyc, 32'(bus.done),         32'(e_done[cyc]));
      chk("float",        cyc, 32'(bus.float),        32'(e_float[cyc]));
      chk("ovf_flag",     cyc, 32'(bus.ovf_flag),     32'(e_ovf[cyc]));
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0; cyc = 0;
    m_float = 1'b0; m_ovf = 1'b0;
    bus.start = 1'b0; bus.num_vectors = '0; bus.float_mode = 1'b0;
    bus.weight_valid = 1'b0; bus.act_valid = 1'b0; bus.ovf_in = 1'b0;

    // reset and idle
    #12;
    check_zero("reset");
    @(negedge clk);
    n_rst = 1'b1;
    clear_stim();
    run_window(10);

    // basic job: 3 vectors, float mode, no stalls
    clear_stim();
    s_start[0] = 1; nv = 3; fm = 1;
    for (int c = 0; c <= L; c++) begin s_wv[c] = 1; s_av[c] = 1; end
    run_window(24);
    chk("pin_load1",  1,  32'(e_load[1]), 32'h1);
    chk("pin_load4",  4,  32'(e_load[4]), 32'h8);
    chk("pin_rv6",    6,  32'(e_rv[6]),   32'h1);
    chk("pin_rv11",   11, 32'(e_rv[11]),  32'h8);
    chk("pin_done17", 17, 32'(e_done[17]), 32'h1);
    chk("pin_busy18", 18, 32'(e_busy[18]), 32'h0);

    // stalls: alternating weight_valid, one-cycle activation bubble
    clear_stim();
    s_start[0] = 1; nv = 3; fm = 1;
    for (int c = 0; c <= L; c++) begin s_wv[c] = (c % 2 == 1); s_av[c] = 1; end
    s_av[9] = 0;
    run_window(30);
    chk("pin_stall_load7", 7,  32'(e_load[7]), 32'h8);
    chk("pin_stall_rv11",  11, 32'(e_rv[11]),  32'h5);
    chk("pin_stall_done",  21, 32'(e_done[21]), 32'h1);

    // zero-length job
    clear_stim();
    s_start[2] = 1; nv = 0; fm = 0;
    run_window(8);
    chk("pin_zero_done3", 3, 32'(e_done[3]), 32'h1);

    // overflow during STREAM sticks through done and idle
    clear_stim();
    s_start[0] = 1; nv = 2; fm = 1; s_ovf[6] = 1;
    for (int c = 0; c <= L; c++) begin s_wv[c] = 1; s_av[c] = 1; end
    run_window(24);
    chk("pin_ovf_hold", 23, 32'(e_ovf[23]), 32'h1);

    // overflow in IDLE ignored, next start clears flag
    clear_stim();
    s_ovf[1] = 1; s_start[3] = 1; nv = 0; s_ovf[8] = 1;
    run_window(12);
    chk("pin_ovf_clear", 11, 32'(e_ovf[11]), 32'h0);

    // overflow during DONE still counts
    clear_stim();
    s_start[0] = 1; nv = 0; s_ovf[1] = 1;
    run_window(6);
    chk("pin_ovf_done", 2, 32'(e_ovf[2]), 32'h1);

    // starts during STREAM and DONE ignored; start right after DONE accepted
    clear_stim();
    s_start[0] = 1; s_start[6] = 1; s_start[17] = 1; s_start[18] = 1; nv = 3; fm = 0;
    for (int c = 0; c <= L; c++) begin s_wv[c] = 1; s_av[c] = 1; end
    run_window(40);
    chk("pin_b2b_done35", 35, 32'(e_done[35]), 32'h1);

    // maximum vector count
    clear_stim();
    s_start[0] = 1; nv = 255; fm = 1;
    for (int c = 0; c <= L; c++) begin s_wv[c] = 1; s_av[c] = 1; end
    run_window(273);
    chk("pin_max_done", 269, 32'(e_done[269]), 32'h1);

    // abort mid-STREAM
    clear_stim();
    s_start[0] = 1; nv = 5; fm = 1;
    for (int c = 0; c <= L; c++) begin s_wv[c] = 1; s_av[c] = 1; end
    run_window(8);
    n_rst = 1'b0;
    #1;
    check_zero("abort");
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.weight_valid = 1'b0; bus.act_valid = 1'b0; bus.ovf_in = 1'b0;
    n_rst   = 1'b1;
    m_float = 1'b0;
    m_ovf   = 1'b0;
    clear_stim();
    run_window(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
